data_mem_resp: RTL and testbench

- Multi-cycle data-memory responder: the slave end of the memory stage's enable/wr/addr/data_in/data_out request interface.
- Replaces the single-cycle memory model with a fixed-latency, word-aligned memory.
- Returns stall while a request is in flight and a one-cycle done pulse when it completes, so the pipeline can be exercised under memory stalls.
- Sits between the memory stage and the data storage.

---
 rtl/data_mem_resp.sv | 110 +++++++++++
 tb/tb_data_mem_resp.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/data_mem_resp.sv
// Fixed-latency, word-aligned data memory responder for the memory stage.
// Accepts one request in IDLE, stalls while it is in flight, then pulses done.
module data_mem_resp #(
    parameter int IDX_BITS = 8,
    parameter int LATENCY  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        wr,
    input  logic [15:0] addr,
    input  logic [15:0] data_in,
    output logic [15:0] data_out,
    output logic        stall,
    output logic        done,
    output logic        err
);
    localparam int DEPTH = 1 << IDX_BITS;
    localparam bit DIRECT = (LATENCY < 2);
    localparam logic [3:0] CNT_INIT = DIRECT ? 4'd0 : 4'(LATENCY - 2);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]          state;
    logic [3:0]          cnt;
    logic [IDX_BITS:0]   req_addr;
    logic [15:0]         req_data;
    logic                req_wr;
    logic                err_q;
    logic [15:0]         mem [DEPTH];

    logic                go_done;
    logic [IDX_BITS:0]   acc_addr;
    logic [15:0]         acc_data;
    logic                acc_wr;
    logic [IDX_BITS-1:0] idx;

    // Only the low IDX_BITS+1 address bits matter; the rest alias.
    if (IDX_BITS < 15) begin : g_alias
        logic unused_hi;
        assign unused_hi = ^addr[15:IDX_BITS+1];
    end

    // With single-cycle latency the access happens on the accepting edge,
    // before the capture registers hold the request, so use the live inputs.
    always_comb begin
        go_done  = ((state == S_IDLE) && enable && DIRECT) ||
                   ((state == S_BUSY) && (cnt == 4'd0));
        acc_addr = (state == S_IDLE) ? addr[IDX_BITS:0] : req_addr;
        acc_data = (state == S_IDLE) ? data_in : req_data;
        acc_wr   = (state == S_IDLE) ? wr : req_wr;
        idx      = acc_addr[IDX_BITS:1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= 4'd0;
            req_addr <= '0;
            req_data <= '0;
            req_wr   <= 1'b0;
            err_q    <= 1'b0;
            data_out <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (enable) begin
                        req_addr <= addr[IDX_BITS:0];
                        req_data <= data_in;
                        req_wr   <= wr;
                        cnt      <= CNT_INIT;
                        state    <= DIRECT ? S_DONE : S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (cnt == 4'd0) begin
                        state <= S_DONE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase

            if (go_done) begin
                if (acc_addr[0]) begin
                    err_q    <= 1'b1;
                    data_out <= '0;
                end else if (acc_wr) begin
                    mem[idx] <= acc_data;
                    err_q    <= 1'b0;
                    data_out <= '0;
                end else begin
                    err_q    <= 1'b0;
                    data_out <= mem[idx];
                end
            end
        end
    end

    assign stall = (state != S_IDLE);
    assign done  = (state == S_DONE);
    assign err   = err_q & done;
endmodule

// File: tb/tb_data_mem_resp.sv
// Bench for data_mem_resp: one instance at LATENCY=2 and one at LATENCY=3,
// vector table, hand sequences and random traffic against a word-array model.
module tb_data_mem_resp;
    logic        clk = 1'b0;
    logic        rst0, rst1, en0, en1, wr;
    logic [15:0] addr, din;
    logic [15:0] dout0, dout1;
    logic        stall0, stall1, done0, done1, err0, err1;

    int n_cmp = 0;
    int n_bad = 0;
    logic [15:0] mm [2][256];

    always #5 clk = ~clk;

    data_mem_resp #(.IDX_BITS(8), .LATENCY(2)) u_l2 (
        .clk(clk), .rst(rst0), .enable(en0), .wr(wr), .addr(addr), .data_in(din),
        .data_out(dout0), .stall(stall0), .done(done0), .err(err0)
    );

    data_mem_resp #(.IDX_BITS(8), .LATENCY(3)) u_l3 (
        .clk(clk), .rst(rst1), .enable(en1), .wr(wr), .addr(addr), .data_in(din),
        .data_out(dout1), .stall(stall1), .done(done1), .err(err1)
    );

    typedef struct {
        logic        w;
        logic [15:0] a;
        logic [15:0] d;
        logic        xe;
        logic [15:0] xq;
    } vec_t;
    vec_t tbl [8];

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic g_stall(int s); return (s == 0) ? stall0 : stall1; endfunction
    function automatic logic g_done(int s);  return (s == 0) ? done0  : done1;  endfunction
    function automatic logic g_err(int s);   return (s == 0) ? err0   : err1;   endfunction
    function automatic logic [15:0] g_dout(int s); return (s == 0) ? dout0 : dout1; endfunction

    task automatic set_en(int s, logic v);
        if (s == 0) en0 = v; else en1 = v;
    endtask

    // Reference: 256-word array indexed by byte address / 2, wrapping at 512 bytes.
    task automatic model(int s, logic w, logic [15:0] a, logic [15:0] d,
                         output logic e, output logic [15:0] q);
        int i;
        i = (a >> 1) & 255;
        if (a[0]) begin
            e = 1'b1; q = 16'h0;
        end else if (w) begin
            mm[s][i] = d; e = 1'b0; q = 16'h0;
        end else begin
            e = 1'b0; q = mm[s][i];
        end
    endtask

    // Issue one request at cycle T and check every cycle through T+lat+1.
    task automatic req(int s, int lat, logic w, logic [15:0] a, logic [15:0] d,
                       logic xe, logic [15:0] xq, string nm);
        chk({nm, ".idle_before"}, g_stall(s), 0);
        wr = w; addr = a; din = d;
        set_en(s, 1'b1);
        tick();
        set_en(s, 1'b0);
        addr = 16'($urandom); din = 16'($urandom); wr = 1'($urandom);
        for (int k = 1; k <= lat; k++) begin
            chk({nm, ".stall"}, g_stall(s), 1);
            chk({nm, ".done"}, g_done(s), 32'(k == lat));
            if (k == lat) begin
                chk({nm, ".err"}, g_err(s), xe);
                chk({nm, ".data_out"}, g_dout(s), xq);
            end
            tick();
        end
        chk({nm, ".stall_after"}, g_stall(s), 0);
        chk({nm, ".done_after"}, g_done(s), 0);
        chk({nm, ".err_after"}, g_err(s), 0);
        chk({nm, ".data_out_held"}, g_dout(s), xq);
    endtask

    task automatic model_req(int s, int lat, logic w, logic [15:0] a, logic [15:0] d, string nm);
        logic        e;
        logic [15:0] q;
        model(s, w, a, d, e, q);
        req(s, lat, w, a, d, e, q, nm);
    endtask

    initial begin
        logic        e;
        logic [15:0] q, a;
        int          ndone;

        tbl[0] = '{1'b0, 16'h0010, 16'h0000, 1'b0, 16'h0000};
        tbl[1] = '{1'b1, 16'h0004, 16'hBEEF, 1'b0, 16'h0000};
        tbl[2] = '{1'b0, 16'h0004, 16'h0000, 1'b0, 16'hBEEF};
        tbl[3] = '{1'b1, 16'h0005, 16'h1234, 1'b1, 16'h0000};
        tbl[4] = '{1'b0, 16'h0004, 16'h0000, 1'b0, 16'hBEEF};
        tbl[5] = '{1'b1, 16'h0202, 16'hA5A5, 1'b0, 16'h0000};
        tbl[6] = '{1'b0, 16'h0002, 16'h0000, 1'b0, 16'hA5A5};
        tbl[7] = '{1'b0, 16'h0003, 16'h0000, 1'b1, 16'h0000};

        for (int s = 0; s < 2; s++)
            for (int i = 0; i < 256; i++)
                mm[s][i] = 16'h0;

        rst0 = 1'b1; rst1 = 1'b1; en0 = 1'b0; en1 = 1'b0;
        wr = 1'b0; addr = 16'h0; din = 16'h0;
        tick(); tick();
        rst0 = 1'b0; rst1 = 1'b0;

        for (int c = 0; c < 5; c++) begin
            chk("reset.stall0", stall0, 0);
            chk("reset.done0", done0, 0);
            chk("reset.err0", err0, 0);
            chk("reset.dout0", dout0, 0);
            chk("reset.stall1", stall1, 0);
            chk("reset.done1", done1, 0);
            chk("reset.dout1", dout1, 0);
            tick();
        end

        for (int i = 0; i < 8; i++) begin
            model(0, tbl[i].w, tbl[i].a, tbl[i].d, e, q);
            req(0, 2, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].xe, tbl[i].xq, $sformatf("vec%0d", i));
        end

        for (int n = 0; n < 40; n++) begin
            a = 16'($urandom);
            a[8:4] = 5'd0;
            a[0] = ($urandom_range(0, 7) == 0);
            model_req((n < 30) ? 0 : 1, (n < 30) ? 2 : 3, 1'($urandom), a, 16'($urandom),
                      $sformatf("rnd%0d", n));
        end

        // Enable held high through the busy window must not start new requests.
        model_req(1, 3, 1'b1, 16'h0010, 16'h5A5A, "hold.wr");
        model(1, 1'b0, 16'h0010, 16'h0, e, q);
        wr = 1'b0; addr = 16'h0010; en1 = 1'b1;
        tick();
        ndone = 0;
        for (int k = 1; k <= 3; k++) begin
            addr = 16'($urandom) & 16'hFFEE;
            wr = 1'($urandom); din = 16'($urandom);
            chk("hold.stall", stall1, 1);
            chk("hold.done", done1, 32'(k == 3));
            if (done1) ndone++;
            if (k == 3) chk("hold.data_out", dout1, q);
            tick();
        end
        chk("hold.one_done", ndone, 1);
        chk("hold.idle_T4", stall1, 0);
        addr = 16'h0010; wr = 1'b0;
        tick();
        chk("hold.accept_T4", stall1, 1);
        en1 = 1'b0;
        tick(); tick();
        chk("hold.done2", done1, 1);
        chk("hold.data_out2", dout1, q);
        tick();

        // Reset during BUSY drops a pending write and clears the whole memory.
        wr = 1'b1; addr = 16'h0008; din = 16'h7777; en1 = 1'b1;
        tick();
        en1 = 1'b0; rst1 = 1'b1;
        chk("rstmid.busy", stall1, 1);
        tick();
        rst1 = 1'b0;
        chk("rstmid.stall", stall1, 0);
        chk("rstmid.done", done1, 0);
        chk("rstmid.err", err1, 0);
        chk("rstmid.dout", dout1, 0);
        for (int c = 0; c < 4; c++) begin
            chk("rstmid.no_done", done1, 0);
            tick();
        end
        for (int i = 0; i < 256; i++) mm[1][i] = 16'h0;
        req(1, 3, 1'b0, 16'h0008, 16'h0, 1'b0, 16'h0000, "rstmid.rd8");
        req(1, 3, 1'b0, 16'h0010, 16'h0, 1'b0, 16'h0000, "rstmid.rd10");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
